// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the FSM state enum and the counter-width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  // Counter must reach WIDTH-1; sized per instance.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
// master drives operands and start; slave returns result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH:0]   diff;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B,
    input  diff, busy, done
  );

  modport slave (
    input  start, A, B,
    output diff, busy, done
  );
endinterface

// File: rtl/serial_subtractor_fs.sv
// 1-bit full subtractor: d = a - b - bin.
// Purely combinational; bout is the borrow out.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor, one bit per clock.
// Define SERIAL_SUB_SAT_EN for saturating underflow.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                resetn,
  serial_subtractor_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam int RW = WIDTH - 1;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [RW-1:0]    r_sr;
  logic [CW-1:0]    cnt;
  logic             bin_q;
  logic             d;
  logic             bout;
  logic             last;
  logic [WIDTH:0]   res_wrap;
  logic [WIDTH:0]   res;
  logic [WIDTH:0]   diff_q;

  fs u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin_q),
    .d    (d),
    .bout (bout)
  );

  assign last     = (cnt == CW'(WIDTH - 1));
  assign res_wrap = {bout, d, r_sr};

`ifdef SERIAL_SUB_SAT_EN
  assign res = bout ? {1'b1, {WIDTH{1'b0}}}
                    : res_wrap;
`else
  assign res = res_wrap;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (bus.start) nxt = LOAD;
      LOAD:  nxt = SHIFT;
      SHIFT: if (last) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Result bits enter at the top so bit 0 ends up at r_sr[0].
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      cnt    <= '0;
      bin_q  <= 1'b0;
      diff_q <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          a_sr  <= bus.A;
          b_sr  <= bus.B;
          bin_q <= 1'b0;
          cnt   <= '0;
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          bin_q <= bout;
          cnt   <= cnt + CW'(1);
          r_sr  <= (r_sr >> 1) | (RW'(d) << (RW - 1));
          if (last) diff_q <= res;
        end
        default: ;
      endcase
    end
  end

  assign bus.diff = diff_q;
  assign bus.busy = (state == LOAD) || (state == SHIFT);
  assign bus.done = (state == DONE);

endmodule
